// File: rtl/fmap_lane_serializer_pkg.sv
// Shared constants and types for the 12-lane fire-stage wrappers.
// The lane serializer and its pixel FIFO import this package.
package fmap_lane_serializer_pkg;

    localparam int LANES_IN  = 12;
    localparam int LANES_OUT = 4;
    localparam int GROUPS    = 3;
    localparam int PIX_DW    = 32;

    typedef logic [LANES_IN*PIX_DW-1:0] pixel_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fmap_pixel_fifo.sv
// Synchronous FIFO holding whole 12-lane pixels. The head entry is always visible.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fmap_pixel_fifo
    import fmap_lane_serializer_pkg::*;
#(
    parameter int W     = LANES_IN*PIX_DW,
    parameter int DEPTH = 4,
    localparam int AW   = clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  data_in,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fmap_lane_serializer.sv
// Buffers 12-lane pixels from a non-stallable stage and replays each one as three
// 4-lane beats under valid/ready. Also counts pixels per frame and flags drops.
module fmap_lane_serializer
    import fmap_lane_serializer_pkg::*;
#(
    parameter int Datawidth        = 32,
    parameter int FIFO_Depth       = 4,
    parameter int Pixels_Per_Frame = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [Datawidth-1:0] In_0,
    input  logic [Datawidth-1:0] In_1,
    input  logic [Datawidth-1:0] In_2,
    input  logic [Datawidth-1:0] In_3,
    input  logic [Datawidth-1:0] In_4,
    input  logic [Datawidth-1:0] In_5,
    input  logic [Datawidth-1:0] In_6,
    input  logic [Datawidth-1:0] In_7,
    input  logic [Datawidth-1:0] In_8,
    input  logic [Datawidth-1:0] In_9,
    input  logic [Datawidth-1:0] In_10,
    input  logic [Datawidth-1:0] In_11,
    input  logic                 ready_out,
    output logic                 valid_out,
    output logic [Datawidth-1:0] Out_0,
    output logic [Datawidth-1:0] Out_1,
    output logic [Datawidth-1:0] Out_2,
    output logic [Datawidth-1:0] Out_3,
    output logic [1:0]           group_idx,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int PW = LANES_IN*Datawidth;
    localparam int CW = clog2(FIFO_Depth) + 1;
    localparam int FW = clog2(Pixels_Per_Frame) + 1;

    typedef enum logic [1:0] {G0 = 2'd0, G1 = 2'd1, G2 = 2'd2} grp_e;

    grp_e                                  grp_q;
    logic [FW-1:0]                         pix_cnt_q, pix_cnt_d;
    logic                                  frame_done_q, overflow_q;
    logic [LANES_IN-1:0][Datawidth-1:0]    pix_in, head_lanes;
    logic [PW-1:0]                         head;
    logic                                  full, empty;
    logic [CW-1:0]                         fifo_count;
    logic                                  beat, pop, drop, last_pix;
    logic [3:0]                            lane_base;
    logic [LANES_OUT-1:0][Datawidth-1:0]   beat_lanes;

    assign pix_in = {In_11, In_10, In_9, In_8, In_7, In_6,
                     In_5,  In_4,  In_3, In_2, In_1, In_0};

    fmap_pixel_fifo #(
        .W     (PW),
        .DEPTH (FIFO_Depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (valid_in),
        .pop     (pop),
        .data_in (pix_in),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count),
        .head    (head)
    );

    assign beat     = !empty && ready_out;
    assign pop      = beat && (grp_q == G2);
    // The upstream cannot stall, so a full FIFO without a same-cycle pop loses the pixel.
    assign drop     = valid_in && full && !pop;
    assign last_pix = (pix_cnt_q == FW'(Pixels_Per_Frame - 1));

    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (pop) pix_cnt_d = last_pix ? '0 : pix_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_q        <= G0;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (beat) begin
                case (grp_q)
                    G0:      grp_q <= G1;
                    G1:      grp_q <= G2;
                    default: grp_q <= G0;
                endcase
            end
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= pop && last_pix;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Beat lanes are a mux over registered head entry and group state only.
    assign head_lanes = head;
    assign lane_base  = {grp_q, 2'b00};

    always_comb begin
        beat_lanes = '0;
        if (!empty)
            for (int j = 0; j < LANES_OUT; j++)
                beat_lanes[j] = head_lanes[lane_base + 4'(j)];
    end

    assign valid_out  = (fifo_count != '0);
    assign Out_0      = beat_lanes[0];
    assign Out_1      = beat_lanes[1];
    assign Out_2      = beat_lanes[2];
    assign Out_3      = beat_lanes[3];
    assign group_idx  = grp_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fmap_lane_serializer.sv
// Directed table-driven bench for fmap_lane_serializer: each row drives one cycle
// and checks the outputs just after that cycle's rising edge.
module tb_fmap_lane_serializer;

    logic        clk = 1'b0;
    logic        rst, valid_in, ready_out;
    logic [31:0] in_w [12];
    logic        valid_out, frame_done, overflow;
    logic [1:0]  group_idx;
    logic [31:0] o0, o1, o2, o3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit rst;
        bit vin;
        int base;
        bit rdy;
        bit ev;
        int eg;
        int eo;
        bit eovf;
        bit efd;
    } vec_t;

    vec_t vec[$];

    fmap_lane_serializer #(
        .Datawidth        (32),
        .FIFO_Depth       (4),
        .Pixels_Per_Frame (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .In_0       (in_w[0]),
        .In_1       (in_w[1]),
        .In_2       (in_w[2]),
        .In_3       (in_w[3]),
        .In_4       (in_w[4]),
        .In_5       (in_w[5]),
        .In_6       (in_w[6]),
        .In_7       (in_w[7]),
        .In_8       (in_w[8]),
        .In_9       (in_w[9]),
        .In_10      (in_w[10]),
        .In_11      (in_w[11]),
        .ready_out  (ready_out),
        .valid_out  (valid_out),
        .Out_0      (o0),
        .Out_1      (o1),
        .Out_2      (o2),
        .Out_3      (o3),
        .group_idx  (group_idx),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic add(input bit r, input bit vin, input int base, input bit rdy,
                       input bit ev, input int eg, input int eo, input bit eovf, input bit efd);
        vec_t v;
        v.rst = r; v.vin = vin; v.base = base; v.rdy = rdy;
        v.ev = ev; v.eg = eg; v.eo = eo; v.eovf = eovf; v.efd = efd;
        vec.push_back(v);
    endtask

    task automatic add_rst();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Drain n buffered pixels (bases 100*(p+s)) whose group-0 beat is already showing.
    task automatic add_drain(input int n, input int s, input bit ovf);
        for (int k = 1; k <= 3*n; k++) begin
            if (k < 3*n) add(0, 0, 0, 1, 1, k % 3, 100*(k/3 + s) + 4*(k % 3), ovf, 0);
            else         add(0, 0, 0, 1, 0, 0, 0, ovf, 0);
        end
    endtask

    // n pixels, one every 3 cycles, ready held high; a full frame ends with the done pulse.
    task automatic add_frame(input int f, input int n, input bit complete);
        for (int e = 0; e < 3*n; e++) begin
            int b;
            b = 1000*f + 20*(e/3);
            add(0, (e % 3) == 0, b, 1, 1, e % 3, b + 4*(e % 3), 0, 0);
        end
        if (complete) begin
            add(0, 0, 0, 1, 0, 0, 0, 0, 1);
            add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic check_row(input string tag, input int i, input vec_t v);
        logic [31:0] e [4];
        bit ok;
        for (int j = 0; j < 4; j++) e[j] = v.ev ? 32'(v.eo + j) : 32'd0;
        ok = (valid_out == v.ev) && (group_idx == 2'(v.eg)) &&
             (o0 == e[0]) && (o1 == e[1]) && (o2 == e[2]) && (o3 == e[3]) &&
             (overflow == v.eovf) && (frame_done == v.efd);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s row %0d: got v=%0d g=%0d out=%0d,%0d,%0d,%0d ovf=%0d fd=%0d, want v=%0d g=%0d out=%0d,%0d,%0d,%0d ovf=%0d fd=%0d",
                     tag, i, valid_out, group_idx, o0, o1, o2, o3, overflow, frame_done,
                     v.ev, v.eg, e[0], e[1], e[2], e[3], v.eovf, v.efd);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (vec[i]) begin
            rst       = vec[i].rst;
            valid_in  = vec[i].vin;
            ready_out = vec[i].rdy;
            for (int k = 0; k < 12; k++)
                in_w[k] = vec[i].vin ? 32'(vec[i].base + k) : 32'hDEAD_0000 + 32'(k);
            @(posedge clk);
            #1;
            check_row(tag, i, vec[i]);
        end
        vec.delete();
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
        for (int k = 0; k < 12; k++) in_w[k] = '0;

        // Reset state, single pixel, then the same pixel under back-pressure.
        add_rst();
        add(0, 1, 1, 1, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 1, 5, 0, 0);
        add(0, 0, 0, 1, 1, 2, 9, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 1, 0, 0);
        for (int c = 0; c < 5; c++) add(0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 1, 5, 0, 0);
        add(0, 0, 0, 1, 1, 2, 9, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        run_table("single");

        // Burst of exactly FIFO_Depth pixels with the sink stalled.
        add_rst();
        for (int p = 0; p < 4; p++) add(0, 1, 100*p, 0, 1, 0, 0, 0, 0);
        add_drain(4, 0, 0);
        run_table("burst");

        // Fifth pixel is dropped; overflow stays set until reset.
        add_rst();
        for (int p = 0; p < 5; p++) add(0, 1, 100*p, 0, 1, 0, 0, p == 4, 0);
        add_drain(4, 0, 1);
        add(0, 1, 900, 0, 1, 0, 900, 1, 0);
        run_table("overflow");

        // Asynchronous reset clears outputs without waiting for an edge.
        rst = 1'b1;
        #2;
        check_val("async_rst valid_out", int'(valid_out), 0);
        check_val("async_rst overflow", int'(overflow), 0);
        check_val("async_rst Out_0", int'(o0), 0);

        // Full FIFO: pop of group 2 and a push on the same edge; the next push must drop.
        add_rst();
        for (int p = 0; p < 4; p++) add(0, 1, 100*p, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 4, 0, 0);
        add(0, 0, 0, 1, 1, 2, 8, 0, 0);
        add(0, 1, 400, 1, 1, 0, 100, 0, 0);
        add(0, 1, 500, 0, 1, 0, 100, 1, 0);
        add_drain(4, 1, 1);
        run_table("push_pop_full");

        // Two back-to-back frames, then a partial third frame.
        add_rst();
        add_frame(1, 16, 1);
        add_frame(2, 16, 1);
        add_frame(3, 7, 0);
        run_table("frames");

        // Mid-frame reset: no done pulse, outputs clear at once.
        rst = 1'b1;
        valid_in = 1'b0;
        #2;
        check_val("midframe_rst valid_out", int'(valid_out), 0);
        check_val("midframe_rst overflow", int'(overflow), 0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check_val("midframe_rst frame_done", int'(frame_done), 0);
        end

        // Counter must restart from zero after the mid-frame reset.
        add_frame(4, 16, 1);
        run_table("frame_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
